// File: rtl/mac32_tb_pkg.sv
// Shared definitions for the MAC32 stimulus driver: FSM states, IEEE-754
// single-precision corner values and LFSR constants.
package mac32_tb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_REPORT = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // +0, -0, +1.0, -1.0, +inf, qNaN, min normal, max finite
  localparam logic [31:0] CORNER_0 = 32'h0000_0000;
  localparam logic [31:0] CORNER_1 = 32'h8000_0000;
  localparam logic [31:0] CORNER_2 = 32'h3F80_0000;
  localparam logic [31:0] CORNER_3 = 32'hBF80_0000;
  localparam logic [31:0] CORNER_4 = 32'h7F80_0000;
  localparam logic [31:0] CORNER_5 = 32'h7FC0_0000;
  localparam logic [31:0] CORNER_6 = 32'h0080_0000;
  localparam logic [31:0] CORNER_7 = 32'h7F7F_FFFF;

  localparam logic [31:0] LFSR_MASK  = 32'h8020_0003;
  localparam logic [31:0] SEED_XOR_B = 32'hA5A5_A5A5;
  localparam logic [31:0] SEED_XOR_C = 32'h5A5A_5A5A;

  function automatic logic [31:0] corner_value(input logic [2:0] k);
    logic [31:0] v;
    case (k)
      3'd0:    v = CORNER_0;
      3'd1:    v = CORNER_1;
      3'd2:    v = CORNER_2;
      3'd3:    v = CORNER_3;
      3'd4:    v = CORNER_4;
      3'd5:    v = CORNER_5;
      3'd6:    v = CORNER_6;
      default: v = CORNER_7;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/mac32_lfsr.sv
// 32-bit right-shifting Galois LFSR with synchronous load and step enable.
// A zero seed would lock the register, so it is replaced by 1 on load.
module mac32_lfsr
  import mac32_tb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        en,
  output logic [31:0] state
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= 32'h0000_0001;
    end else if (load) begin
      state <= (seed == 32'h0) ? 32'h0000_0001 : seed;
    end else if (en) begin
      state <= {1'b0, state[31:1]} ^ (state[0] ? LFSR_MASK : 32'h0);
    end
  end

endmodule

// File: rtl/mac32_stim_driver.sv
// Stimulus driver for a floating-point MAC: issues A/B/C operand triples,
// waits a fixed latency, captures the result and reports it to a checker.
module mac32_stim_driver
  import mac32_tb_pkg::*;
#(
  parameter int PARM_XLEN = 32,
  parameter int PARM_EXP  = 8,
  parameter int PARM_MANT = 23,
  parameter int PARM_BIAS = 127,
  parameter int PARM_LAT  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [15:0]          num_ops_i,
  input  logic [31:0]          seed_i,
  input  logic                 mode_i,
  output logic [PARM_XLEN-1:0] A_o,
  output logic [PARM_XLEN-1:0] B_o,
  output logic [PARM_XLEN-1:0] C_o,
  output logic                 op_valid_o,
  input  logic                 dut_ready_i,
  input  logic [PARM_XLEN-1:0] Result_i,
  output logic                 chk_valid_o,
  output logic [PARM_XLEN-1:0] chk_A_o,
  output logic [PARM_XLEN-1:0] chk_B_o,
  output logic [PARM_XLEN-1:0] chk_C_o,
  output logic [PARM_XLEN-1:0] chk_Result_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [15:0]          issued_cnt_o,
  output logic [2:0]           state_o
);

  localparam int LAT_W = (PARM_LAT > 1) ? $clog2(PARM_LAT) : 1;

  if (PARM_LAT < 1 || PARM_EXP + PARM_MANT + 1 != PARM_XLEN ||
      PARM_BIAS != (1 << (PARM_EXP - 1)) - 1) begin : g_bad_param
    $error("mac32_stim_driver: inconsistent float format or latency parameters");
  end

  // Handshake: an operand triple transfers on any rising edge where
  // op_valid_o and dut_ready_i are both high; op_valid_o never drops and the
  // operands never change while waiting for dut_ready_i.

  state_e             state, state_nx;
  logic [15:0]        num_ops_q;
  logic               mode_q;
  logic [LAT_W-1:0]   lat_q;
  logic [31:0]        lfsr_a, lfsr_b, lfsr_c;
  logic [31:0]        gen_a, gen_b, gen_c;
  logic               start_acc, handshake, last_op, lfsr_step;

  assign start_acc = (state == ST_IDLE) && start_i;
  assign handshake = (state == ST_ISSUE) && dut_ready_i;
  assign last_op   = (issued_cnt_o + 16'd1) == num_ops_q;
  assign lfsr_step = (state == ST_REPORT);

  mac32_lfsr u_lfsr_a (.clk(clk), .rst(rst), .load(start_acc), .seed(seed_i),
                       .en(lfsr_step), .state(lfsr_a));
  mac32_lfsr u_lfsr_b (.clk(clk), .rst(rst), .load(start_acc), .seed(seed_i ^ SEED_XOR_B),
                       .en(lfsr_step), .state(lfsr_b));
  mac32_lfsr u_lfsr_c (.clk(clk), .rst(rst), .load(start_acc), .seed(seed_i ^ SEED_XOR_C),
                       .en(lfsr_step), .state(lfsr_c));

  // Corner index follows the completed-op count, so it only moves in REPORT.
  always_comb begin
    gen_a = lfsr_a;
    gen_b = lfsr_b;
    gen_c = lfsr_c;
    if (mode_q) begin
      gen_a = corner_value(issued_cnt_o[2:0]);
      gen_b = corner_value(issued_cnt_o[2:0] + 3'd3);
      gen_c = corner_value(issued_cnt_o[2:0] + 3'd5);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (start_i) state_nx = (num_ops_i == 16'd0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE:  if (dut_ready_i) state_nx = ST_WAIT;
      ST_WAIT:   if (lat_q == '0) state_nx = ST_REPORT;
      ST_REPORT: state_nx = last_op ? ST_DONE : ST_ISSUE;
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    op_valid_o  = (state == ST_ISSUE);
    chk_valid_o = (state == ST_REPORT);
    done_o      = (state == ST_DONE);
    busy_o      = (state != ST_IDLE);
    state_o     = state;
    A_o         = '0;
    B_o         = '0;
    C_o         = '0;
    if (state == ST_ISSUE) begin
      A_o = PARM_XLEN'(gen_a);
      B_o = PARM_XLEN'(gen_b);
      C_o = PARM_XLEN'(gen_c);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_ops_q    <= '0;
      mode_q       <= 1'b0;
      lat_q        <= '0;
      issued_cnt_o <= '0;
      chk_A_o      <= '0;
      chk_B_o      <= '0;
      chk_C_o      <= '0;
      chk_Result_o <= '0;
    end else begin
      if (start_acc) begin
        num_ops_q    <= num_ops_i;
        mode_q       <= mode_i;
        issued_cnt_o <= '0;
      end
      if (handshake) begin
        chk_A_o <= PARM_XLEN'(gen_a);
        chk_B_o <= PARM_XLEN'(gen_b);
        chk_C_o <= PARM_XLEN'(gen_c);
        lat_q   <= LAT_W'(PARM_LAT - 1);
      end
      if (state == ST_WAIT) begin
        if (lat_q == '0) chk_Result_o <= Result_i;
        else             lat_q <= lat_q - 1'b1;
      end
      if (state == ST_REPORT) issued_cnt_o <= issued_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_mac32_stim_driver.sv
// Bench for mac32_stim_driver: randomized runs checked every cycle against a
// transaction-level model of the operand generator and handshake timing.
module tb_mac32_stim_driver;
  import mac32_tb_pkg::*;

  localparam int XLEN = 32;
  localparam int LAT  = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            start_i = 1'b0;
  logic [15:0]     num_ops_i = '0;
  logic [31:0]     seed_i = '0;
  logic            mode_i = 1'b0;
  logic            dut_ready_i = 1'b0;
  logic [XLEN-1:0] Result_i = '0;
  logic [XLEN-1:0] A_o, B_o, C_o, chk_A_o, chk_B_o, chk_C_o, chk_Result_o;
  logic            op_valid_o, chk_valid_o, busy_o, done_o;
  logic [15:0]     issued_cnt_o;
  logic [2:0]      state_o;

  mac32_stim_driver #(.PARM_XLEN(XLEN), .PARM_EXP(8), .PARM_MANT(23),
                      .PARM_BIAS(127), .PARM_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .num_ops_i(num_ops_i),
    .seed_i(seed_i), .mode_i(mode_i), .A_o(A_o), .B_o(B_o), .C_o(C_o),
    .op_valid_o(op_valid_o), .dut_ready_i(dut_ready_i), .Result_i(Result_i),
    .chk_valid_o(chk_valid_o), .chk_A_o(chk_A_o), .chk_B_o(chk_B_o),
    .chk_C_o(chk_C_o), .chk_Result_o(chk_Result_o), .busy_o(busy_o),
    .done_o(done_o), .issued_cnt_o(issued_cnt_o), .state_o(state_o)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] corner_t [8] = '{32'h00000000, 32'h80000000, 32'h3F800000, 32'hBF800000,
                                32'h7F800000, 32'h7FC00000, 32'h00800000, 32'h7F7FFFFF};

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
  endfunction

  bit          m_busy = 0, m_issue = 0, m_pend = 0, m_mode = 0;
  int          m_num = 0, m_cnt = 0, m_hs_cyc = 0, m_done_due = -1, cyc = 0;
  logic [31:0] m_la, m_lb, m_lc, m_pa, m_pb, m_pc, m_pr;
  bit          was_busy, exp_valid, m_first_op, m_first_chk;
  int          n_chk = 0, n_done = 0, n_hs = 0, n_acc = 0, last_hs_cyc = 0, last_chk_cyc = 0;
  logic [31:0] first_a, first_b, first_c, second_a, first_chk_a, first_chk_b, first_chk_c;

  function automatic logic [31:0] model_op(input int off);
    if (m_mode) return corner_t[(m_cnt + off) % 8];
    case (off)
      0:       return m_la;
      3:       return m_lb;
      default: return m_lc;
    endcase
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      check("rst_op_valid", op_valid_o, 0);
      check("rst_chk_valid", chk_valid_o, 0);
      check("rst_done", done_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_A", A_o, 0);
      check("rst_B", B_o, 0);
      check("rst_C", C_o, 0);
      check("rst_chk_A", chk_A_o, 0);
      check("rst_chk_B", chk_B_o, 0);
      check("rst_chk_C", chk_C_o, 0);
      check("rst_chk_R", chk_Result_o, 0);
      check("rst_cnt", issued_cnt_o, 0);
      check("rst_state", state_o, ST_IDLE);
      m_busy = 0; m_issue = 0; m_pend = 0; m_cnt = 0; m_done_due = -1;
    end else begin
      was_busy  = m_busy;
      exp_valid = m_pend && (cyc == m_hs_cyc + LAT + 1);
      check("op_valid", op_valid_o, m_issue);
      check("chk_valid", chk_valid_o, exp_valid);
      check("done", done_o, cyc == m_done_due);
      check("busy", busy_o, m_busy);
      check("issued_cnt", issued_cnt_o, m_cnt);
      if (chk_valid_o) n_chk++;
      if (done_o) n_done++;
      if (m_issue) begin
        check("A_o", A_o, model_op(0));
        check("B_o", B_o, model_op(3));
        check("C_o", C_o, model_op(5));
        if (m_first_op) begin
          first_a = A_o; first_b = B_o; first_c = C_o; m_first_op = 0;
        end
        if (m_cnt == 1) second_a = A_o;
        if (dut_ready_i) begin
          n_hs++; last_hs_cyc = cyc;
          m_issue = 0; m_pend = 1; m_hs_cyc = cyc;
          m_pa = model_op(0); m_pb = model_op(3); m_pc = model_op(5);
        end
      end
      if (m_pend && cyc == m_hs_cyc + LAT) m_pr = Result_i;
      if (exp_valid) begin
        check("chk_A", chk_A_o, m_pa);
        check("chk_B", chk_B_o, m_pb);
        check("chk_C", chk_C_o, m_pc);
        check("chk_Result", chk_Result_o, m_pr);
        if (m_first_chk) begin
          first_chk_a = chk_A_o; first_chk_b = chk_B_o; first_chk_c = chk_C_o; m_first_chk = 0;
        end
        last_chk_cyc = cyc;
        m_cnt++;
        m_la = lfsr_next(m_la); m_lb = lfsr_next(m_lb); m_lc = lfsr_next(m_lc);
        m_pend = 0;
        if (m_cnt == m_num) m_done_due = cyc + 1;
        else m_issue = 1;
      end
      if (cyc == m_done_due) begin
        m_busy = 0; m_done_due = -1;
      end
      if (!was_busy && start_i) begin
        n_acc++;
        m_busy = 1; m_cnt = 0; m_num = num_ops_i; m_mode = mode_i;
        m_la = (seed_i == 0) ? 32'h1 : seed_i;
        m_lb = ((seed_i ^ 32'hA5A5A5A5) == 0) ? 32'h1 : (seed_i ^ 32'hA5A5A5A5);
        m_lc = ((seed_i ^ 32'h5A5A5A5A) == 0) ? 32'h1 : (seed_i ^ 32'h5A5A5A5A);
        m_first_op = 1; m_first_chk = 1;
        if (num_ops_i == 0) m_done_due = cyc + 1;
        else m_issue = 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  int rdy_mode = 1;  // 0 random, 1 always ready, 2 never ready
  always @(posedge clk) begin
    #1;
    Result_i = $urandom;
    case (rdy_mode)
      0:       dut_ready_i = ($urandom_range(0, 2) != 0);
      1:       dut_ready_i = 1'b1;
      default: dut_ready_i = 1'b0;
    endcase
  end

  task automatic start_run(input logic [15:0] n, input logic [31:0] s, input logic m, input bit hold);
    @(posedge clk); #2;
    start_i = 1'b1; num_ops_i = n; seed_i = s; mode_i = m;
    if (!hold) begin
      @(posedge clk); #2;
      start_i = 1'b0;
    end
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0 = n_done;
    int k = 0;
    while (n_done == d0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    check({"timeout_", name}, k < budget, 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int c0, d0, h0, a0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // zero-op run: straight to DONE, nothing reported
    c0 = n_chk;
    start_run(16'd0, 32'h0, 1'b0, 0);
    wait_done(20, "zero_ops");
    #3 check("zero_ops_cnt", issued_cnt_o, 0);
    check("zero_ops_chk_pulses", n_chk - c0, 0);

    // corner table, always ready
    rdy_mode = 1;
    c0 = n_chk;
    start_run(16'd8, 32'h0, 1'b1, 0);
    wait_done(200, "corner8");
    check("corner8_pulses", n_chk - c0, 8);
    check("corner8_first_A", first_chk_a, 32'h00000000);
    check("corner8_first_B", first_chk_b, 32'hBF800000);
    check("corner8_first_C", first_chk_c, 32'h7FC00000);
    check("hs_to_chk_cycles", last_chk_cyc - last_hs_cyc, 4);

    // random mode, zero seed, repeated
    rdy_mode = 0;
    for (int r = 0; r < 2; r++) begin
      start_run(16'd6, 32'h0, 1'b0, 0);
      wait_done(400, "seed0");
      check("seed0_first_A", first_a, 32'h00000001);
      check("seed0_first_B", first_b, 32'hA5A5A5A5);
      check("seed0_first_C", first_c, 32'h5A5A5A5A);
      check("seed0_second_A", second_a, 32'h80200003);
    end

    // stall in ISSUE for 10 cycles
    rdy_mode = 2;
    h0 = n_hs;
    start_run(16'd2, 32'h1234_5678, 1'b0, 0);
    repeat (10) @(posedge clk);
    #3 check("stall_op_valid", op_valid_o, 1);
    check("stall_no_hs", n_hs - h0, 0);
    rdy_mode = 1;
    wait_done(100, "stall");
    check("stall_hs_total", n_hs - h0, 2);

    // reset during WAIT of op 3 of 5, then a clean 5-op run
    h0 = n_hs;
    start_run(16'd5, 32'hCAFE_0001, 1'b1, 0);
    a0 = 0;
    while (n_hs - h0 < 3 && a0 < 200) begin
      @(posedge clk);
      a0++;
    end
    check("reach_op3", a0 < 200, 1);
    c0 = n_chk; d0 = n_done;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 check("midrun_rst_state", state_o, ST_IDLE);
    check("midrun_rst_no_chk", n_chk - c0, 0);
    check("midrun_rst_no_done", n_done - d0, 0);
    rst = 1'b0;
    c0 = n_chk;
    start_run(16'd5, 32'hCAFE_0001, 1'b1, 0);
    wait_done(200, "after_rst");
    check("after_rst_pulses", n_chk - c0, 5);

    // start held high across a 2-op run
    a0 = n_acc;
    start_run(16'd2, 32'h0BAD_F00D, 1'b0, 1);
    wait_done(100, "held_start");
    check("held_start_one_run", n_acc - a0, 1);
    @(posedge clk); #2 start_i = 1'b0;
    wait_done(100, "held_start2");
    check("held_start_rerun_from_idle", n_acc - a0, 2);

    // large count: latch and count without wrap, then abort
    rdy_mode = 1;
    start_run(16'hFFFF, 32'h7777_0000, 1'b0, 0);
    repeat (200) @(posedge clk);
    #3 check("big_run_busy", busy_o, 1);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;

    // randomized runs
    rdy_mode = 0;
    for (int r = 0; r < 6; r++) begin
      start_run(16'($urandom_range(1, 12)), $urandom, 1'($urandom_range(0, 1)), 0);
      wait_done(2000, "random_run");
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
